// File: rtl/load_store_unit.sv
// Load/store unit: one memory access at a time over a req/ack word bus, with
// extended load writeback and timeout abort. Optional misalignment trap: MEM_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd_addr,
  output logic        hold_en,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;

  logic        misaligned;
  logic [3:0]  strb_new;
  logic [31:0] wdata_new;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

`ifdef MEM_MISALIGN_TRAP_EN
  logic is_byte, is_half;
  // Loads decode width from funct3[1:0] (bit 2 is signedness); stores use the full code.
  assign is_byte    = req_we ? (req_funct3 == 3'b000) : (req_funct3[1:0] == 2'b00);
  assign is_half    = req_we ? (req_funct3 == 3'b001) : (req_funct3[1:0] == 2'b01);
  assign misaligned = is_half ? req_addr[0] : (!is_byte && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    strb_new  = 4'b1111;
    wdata_new = req_wdata;
    case (req_funct3)
      3'b000: begin
        strb_new  = 4'b0001 << req_addr[1:0];
        wdata_new = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        strb_new  = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = bus_rdata[{lane_q, 3'b000} +: 8];
    ld_half   = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = bus_rdata;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    lane_d    = lane_q;
    rd_d      = rd_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    err_d     = 1'b0;
    mis_d     = 1'b0;
    hold_en   = 1'b0;
    bus_req   = 1'b0;
    case (state_q)
      IDLE: begin
        hold_en = req_valid;
        if (req_valid) begin
          cnt_d = '0;
          if (misaligned) begin
            state_d = DONE;
            mis_d   = 1'b1;
          end else begin
            state_d  = BUS;
            we_d     = req_we;
            addr_d   = {req_addr[31:2], 2'b00};
            strb_d   = strb_new;
            wdata_d  = wdata_new;
            funct3_d = req_funct3;
            lane_d   = req_addr[1:0];
            rd_d     = req_rd_addr;
          end
        end
      end
      BUS: begin
        hold_en = 1'b1;
        bus_req = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        if (bus_ack) begin
          state_d = DONE;
          if (!we_q) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = load_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      strb_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      lane_q    <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      lane_q    <= lane_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
    end
  end

  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_wstrb    = strb_q;
  assign bus_wdata    = wdata_q;
  assign wb_en        = wb_en_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign bus_err      = err_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases plus randomized
// back-to-back accesses against a byte-level reference model.
module tb_load_store_unit;

  localparam int T_OUT = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd_addr = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        hold_en, bus_req, bus_we, wb_en, bus_err, misalign_err;
  logic [31:0] bus_addr, bus_wdata, wb_data;
  logic [3:0]  bus_wstrb;
  logic [4:0]  wb_addr;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.TIMEOUT_CYCLES(T_OUT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd_addr(req_rd_addr),
    .hold_en(hold_en), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Observations of the most recent access
  logic        obs_hold_req, obs_hold_done, obs_stable, obs_hold_bus, obs_pulse_ok, obs_hung;
  logic        obs_wb, obs_err, obs_mis, obs_bus_we;
  logic [31:0] obs_bus_addr, obs_bus_wdata, obs_wb_data, obs_wb_data_after;
  logic [3:0]  obs_bus_strb;
  logic [4:0]  obs_wb_addr;
  int          obs_req_cycles, obs_done_cyc;
  logic [31:0] exp_last_wb;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] ld;
    logic        mis;
  } exp_t;

  // Reference: an access touches `size` bytes at the size-aligned offset inside the word.
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t m;
    int size, lane, off;
    logic [31:0] v;
    if (we) size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    lane = int'(addr[1:0]);
    off  = (lane / size) * size;
    m.addr = addr - 32'(lane);
    m.strb = '0;
    for (int i = 0; i < size; i++) m.strb[off + i] = 1'b1;
    for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    v = rdata >> (8 * off);
    if (size == 1)      m.ld = (!f3[2] && v[7])  ? {24'hFFFFFF, v[7:0]} : {24'h0, v[7:0]};
    else if (size == 2) m.ld = (!f3[2] && v[15]) ? {16'hFFFF, v[15:0]}  : {16'h0, v[15:0]};
    else                m.ld = rdata;
`ifdef MEM_MISALIGN_TRAP_EN
    m.mis = (lane % size) != 0;
`else
    m.mis = 1'b0;
`endif
    return m;
  endfunction

  // Drives one access starting at a falling edge in IDLE; returns at the falling edge after DONE.
  // ack_at = index of the BUS cycle carrying bus_ack (0 = never).
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd,
                            input logic [31:0] rdata, input int ack_at);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd_addr = rd;
    #1 obs_hold_req = hold_en;
    obs_req_cycles = 0; obs_done_cyc = 0; obs_stable = 1'b1; obs_hold_bus = 1'b1;
    obs_hung = 1'b1; obs_pulse_ok = 1'b0;
    obs_bus_we = 1'bx; obs_bus_addr = 'x; obs_bus_strb = 'x; obs_bus_wdata = 'x;
    @(negedge sys_clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_rd_addr = 5'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus_req) begin
        obs_req_cycles++;
        if (obs_req_cycles == 1) begin
          obs_bus_we = bus_we; obs_bus_addr = bus_addr;
          obs_bus_strb = bus_wstrb; obs_bus_wdata = bus_wdata;
        end else if ({bus_we, bus_addr, bus_wstrb, bus_wdata} !==
                     {obs_bus_we, obs_bus_addr, obs_bus_strb, obs_bus_wdata}) begin
          obs_stable = 1'b0;
        end
        if (hold_en !== 1'b1) obs_hold_bus = 1'b0;
        bus_ack   = (obs_req_cycles == ack_at);
        bus_rdata = bus_ack ? rdata : $urandom;
        @(negedge sys_clk);
      end else begin
        bus_ack = 1'b0;
        obs_done_cyc = cyc;
        obs_wb = wb_en; obs_wb_addr = wb_addr; obs_wb_data = wb_data;
        obs_err = bus_err; obs_mis = misalign_err;
        req_valid = 1'b1;
        #1 obs_hold_done = hold_en;
        @(negedge sys_clk);
        req_valid = 1'b0;
        #1 obs_pulse_ok = !wb_en && !bus_err && !misalign_err && !bus_req && !hold_en;
        obs_wb_data_after = wb_data;
        obs_hung = 1'b0;
        break;
      end
    end
    bus_ack = 1'b0;
    if (!obs_hung) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    logic quiet;
    #12;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, wb_en, wb_addr, wb_data, bus_err, misalign_err, hold_en} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs wb_data=%h bus_addr=%h", wb_data, bus_addr);
    end
    @(negedge sys_clk); sys_rst_n = 1'b1;
    @(negedge sys_clk);
    run_access(1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd7, 32'hDEAD_BEEF, 1);
    checks++;
    if (obs_wb_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL reset_preload: got %h want %h", obs_wb_data, 32'hDEAD_BEEF);
    end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_6000; req_rd_addr = 5'd9;
    @(negedge sys_clk); req_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (bus_req !== 1'b1) begin
      errors++; $display("FAIL reset_mid_bus_req: got %b want 1", bus_req);
    end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, wb_en, wb_addr, wb_data, bus_err, misalign_err, hold_en} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got bus_req=%b wb_data=%h bus_addr=%h", bus_req, wb_data, bus_addr);
    end
    @(negedge sys_clk); sys_rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
    @(negedge sys_clk); bus_ack = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, wb_en, wb_addr, wb_data, bus_err, misalign_err, hold_en} !== '0)
        quiet = 1'b0;
      @(negedge sys_clk);
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++; $display("FAIL reset_late_ack: got activity want all outputs 0");
    end
    exp_last_wb = 32'h0;
  endtask

  task automatic test_store_sb();
    run_access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd3, $urandom, 2);
    checks++; if (obs_bus_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h want %h", obs_bus_addr, 32'h0000_1000); end
    checks++; if (obs_bus_strb !== 4'b1000) begin errors++; $display("FAIL sb_strb: got %b want 1000", obs_bus_strb); end
    checks++; if (obs_bus_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", obs_bus_wdata); end
    checks++; if (obs_bus_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b want 1", obs_bus_we); end
    checks++; if (obs_wb !== 1'b0) begin errors++; $display("FAIL sb_wb_en: got %b want 0", obs_wb); end
    checks++; if (obs_hold_done !== 1'b0) begin errors++; $display("FAIL sb_hold_done: got %b want 0", obs_hold_done); end
    checks++; if (obs_req_cycles !== 2 || obs_done_cyc !== 3) begin
      errors++; $display("FAIL sb_timing: got req=%0d done=%0d want req=2 done=3", obs_req_cycles, obs_done_cyc); end
    checks++; if (obs_wb_data_after !== exp_last_wb) begin errors++; $display("FAIL sb_wb_hold: got %h want %h", obs_wb_data_after, exp_last_wb); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ad [5] = '{32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h2000};
    logic [31:0] rd [5] = '{32'h1234_80FF, 32'h1234_80FF, 32'h8001_0000, 32'h8001_0000, 32'h8001_0000};
    logic [31:0] ex [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000};
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, f3[i], ad[i], $urandom, 5'(10 + i), rd[i], 1);
      checks++; if (obs_wb !== 1'b1 || obs_wb_data !== ex[i]) begin
        errors++; $display("FAIL load%0d_data: got en=%b data=%h want en=1 data=%h", i, obs_wb, obs_wb_data, ex[i]); end
      checks++; if (obs_wb_addr !== 5'(10 + i) || obs_done_cyc !== 2) begin
        errors++; $display("FAIL load%0d_wb: got rd=%0d cyc=%0d want rd=%0d cyc=2", i, obs_wb_addr, obs_done_cyc, 10 + i); end
      checks++; if (obs_pulse_ok !== 1'b1 || obs_wb_data_after !== ex[i]) begin
        errors++; $display("FAIL load%0d_pulse: got pulse_ok=%b after=%h want 1 %h", i, obs_pulse_ok, obs_wb_data_after, ex[i]); end
      exp_last_wb = ex[i];
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd9, 32'h0, 0);
    checks++; if (obs_req_cycles !== T_OUT || obs_done_cyc !== T_OUT + 1) begin
      errors++; $display("FAIL timeout_len: got req=%0d done=%0d want %0d %0d", obs_req_cycles, obs_done_cyc, T_OUT, T_OUT + 1); end
    checks++; if (obs_err !== 1'b1 || obs_wb !== 1'b0) begin
      errors++; $display("FAIL timeout_flags: got err=%b wb=%b want err=1 wb=0", obs_err, obs_wb); end
    checks++; if (obs_pulse_ok !== 1'b1 || obs_wb_data_after !== exp_last_wb) begin
      errors++; $display("FAIL timeout_after: got pulse_ok=%b wb_data=%h want 1 %h", obs_pulse_ok, obs_wb_data_after, exp_last_wb); end
    run_access(1'b0, 3'b010, 32'h0000_4004, 32'h0, 5'd12, 32'h5555_AAAA, T_OUT);
    checks++; if (obs_err !== 1'b0 || obs_wb !== 1'b1 || obs_wb_data !== 32'h5555_AAAA) begin
      errors++; $display("FAIL ack_last_cycle: got err=%b wb=%b data=%h want 0 1 5555aaaa", obs_err, obs_wb, obs_wb_data); end
    checks++; if (obs_req_cycles !== T_OUT) begin
      errors++; $display("FAIL ack_last_len: got %0d want %0d", obs_req_cycles, T_OUT); end
    exp_last_wb = 32'h5555_AAAA;
  endtask

  task automatic test_misalign();
    run_access(1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd11, 32'h0BAD_F00D, 1);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (obs_req_cycles !== 0 || obs_mis !== 1'b1 || obs_wb !== 1'b0 || obs_done_cyc !== 1) begin
      errors++; $display("FAIL misalign_trap: got req=%0d mis=%b wb=%b cyc=%0d want 0 1 0 1", obs_req_cycles, obs_mis, obs_wb, obs_done_cyc); end
    checks++; if (obs_hold_req !== 1'b1 || obs_hold_done !== 1'b0 || obs_pulse_ok !== 1'b1) begin
      errors++; $display("FAIL misalign_hold: got req=%b done=%b pulse=%b want 1 0 1", obs_hold_req, obs_hold_done, obs_pulse_ok); end
`else
    checks++; if (obs_bus_addr !== 32'h0000_3000 || obs_mis !== 1'b0) begin
      errors++; $display("FAIL misalign_forced: got addr=%h mis=%b want 00003000 0", obs_bus_addr, obs_mis); end
    checks++; if (obs_wb !== 1'b1 || obs_wb_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL misalign_load: got wb=%b data=%h want 1 0badf00d", obs_wb, obs_wb_data); end
    exp_last_wb = 32'h0BAD_F00D;
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic we, done_ok;
    logic [2:0] f3;
    logic [31:0] addr, wdata, rdata;
    logic [4:0] rd;
    int ack_at, exp_req;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      rdata = $urandom; rd = 5'($urandom); ack_at = int'($urandom_range(0, T_OUT + 2));
      e = model(we, f3, addr, wdata, rdata);
      done_ok = !e.mis && ack_at >= 1 && ack_at <= T_OUT;
      exp_req = e.mis ? 0 : (done_ok ? ack_at : T_OUT);
      run_access(we, f3, addr, wdata, rd, rdata, ack_at);
      checks++; if (obs_hung !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_hang: no DONE within bound", n); end
      checks++; if (obs_req_cycles !== exp_req || obs_done_cyc !== exp_req + 1) begin
        errors++; $display("FAIL rnd%0d_timing: got req=%0d done=%0d want %0d %0d", n, obs_req_cycles, obs_done_cyc, exp_req, exp_req + 1); end
      checks++; if (obs_wb !== (done_ok && !we) || obs_err !== (!e.mis && !done_ok) || obs_mis !== e.mis) begin
        errors++; $display("FAIL rnd%0d_flags: got wb=%b err=%b mis=%b want %b %b %b", n, obs_wb, obs_err, obs_mis,
                           done_ok && !we, !e.mis && !done_ok, e.mis); end
      if (!e.mis) begin
        checks++; if (obs_bus_addr !== e.addr || obs_bus_we !== we || obs_stable !== 1'b1 || obs_hold_bus !== 1'b1) begin
          errors++; $display("FAIL rnd%0d_bus: got addr=%h we=%b stable=%b hold=%b want %h %b 1 1", n, obs_bus_addr, obs_bus_we,
                             obs_stable, obs_hold_bus, e.addr, we); end
      end
      if (!e.mis && we) begin
        checks++; if (obs_bus_strb !== e.strb || obs_bus_wdata !== e.wdata) begin
          errors++; $display("FAIL rnd%0d_store: got strb=%b wdata=%h want %b %h", n, obs_bus_strb, obs_bus_wdata, e.strb, e.wdata); end
      end
      if (done_ok && !we) begin
        checks++; if (obs_wb_data !== e.ld || obs_wb_addr !== rd) begin
          errors++; $display("FAIL rnd%0d_load: got data=%h rd=%0d want %h %0d", n, obs_wb_data, obs_wb_addr, e.ld, rd); end
        exp_last_wb = e.ld;
      end
      checks++; if (obs_hold_req !== 1'b1 || obs_hold_done !== 1'b0 || obs_pulse_ok !== 1'b1 || obs_wb_data_after !== exp_last_wb) begin
        errors++; $display("FAIL rnd%0d_after: got hreq=%b hdone=%b pulse=%b wb_data=%h want 1 0 1 %h", n, obs_hold_req,
                           obs_hold_done, obs_pulse_ok, obs_wb_data_after, exp_last_wb); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_last_wb = 32'h0;
    test_reset();
    test_store_sb();
    test_loads();
    test_timeout();
    test_misalign();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execution stage.
- Accepts one load/store request at a time and drives a word-wide data-RAM bus with a req/ack handshake.
- Returns sign- or zero-extended load data for register-file writeback.
- Stalls the pipeline through hold_en while the access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum bus_req cycles without bus_ack before the access is aborted; legal range 1..65535.

Ports:
- sys_clk  input  1  clock, all state on rising edge
- sys_rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  execution presents a memory instruction
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width/sign code
- req_addr  input  32  effective byte address
- req_wdata  input  32  store data from rs2
- req_rd_addr  input  5  load destination register
- hold_en  output  1  stall for if_id/id_ex/PC
- bus_req  output  1  bus request
- bus_we  output  1  bus write
- bus_addr  output  32  word address, bits[1:0] = 0
- bus_wstrb  output  4  byte write strobes
- bus_wdata  output  32  lane-replicated store data
- bus_ack  input  1  single-cycle completion pulse
- bus_rdata  input  32  read data, valid with bus_ack
- wb_en  output  1  one-cycle writeback strobe
- wb_addr  output  5  writeback register
- wb_data  output  32  extended load result
- bus_err  output  1  one-cycle timeout pulse
- misalign_err  output  1  one-cycle misalignment pulse (tied 0 when MEM_MISALIGN_TRAP_EN is undefined)

Behaviour:
- Reset: state IDLE. All registered outputs and internal latches are 0: bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, wb_en, wb_addr, wb_data, bus_err, misalign_err, timeout counter.
- Reset is honoured mid-access. An in-flight request is dropped, and a late bus_ack after reset is ignored.
- FSM has three states: IDLE, BUS, DONE.
  - IDLE: if req_valid, latch the request, compute strobes and data, and go to BUS. hold_en = req_valid (combinational) in IDLE.
  - BUS: bus_req = 1 and all bus outputs stay stable until bus_ack. hold_en = 1. The counter increments each BUS cycle.
    - On bus_ack, go to DONE.
    - When the counter equals TIMEOUT_CYCLES-1 with no ack, go to DONE and pulse bus_err.
    - bus_ack takes priority over timeout in the same cycle.
  - DONE: exactly one cycle. For a load completed by ack: wb_en = 1, wb_addr = latched rd, wb_data = extracted value. For stores and timeouts: wb_en = 0. hold_en = 0, so the pipeline advances at the end of DONE. req_valid is ignored in DONE. Next state is IDLE.
- Latency: request in cycle 0, bus_req from cycle 1, ack in cycle k ≥ 1, writeback in cycle k+1. Back-to-back requests therefore have a minimum of 3 cycles each.
- bus_ack outside BUS is ignored.
- Strobes (lane = addr[1:0]):
  - SB (000): 4'b0001 << lane, wdata = {4{byte}}.
  - SH (001): 4'b0011 << {addr[1],1'b0}, wdata = {2{half}}.
  - SW (010) and any other funct3: 4'b1111.
- Loads:
  - LB/LBU select byte = lane.
  - LH/LHU select the half chosen by addr[1].
  - LB/LH sign-extend; LBU (100)/LHU (101) zero-extend.
  - LW and undefined codes (011, 110, 111) return the full word.
- wb_data holds its last value when wb_en = 0; only wb_en qualifies it.
- rd = x0 loads still perform the bus read. wb_en asserts with wb_addr = 0, and the register file discards the write.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0] = 1, or word with addr[1:0] ≠ 0, is not issued.
  - IDLE goes straight to DONE, with misalign_err pulsed in DONE, wb_en = 0, and no bus_req.
- Undefined:
  - misalign_err is tied 0.
  - Low address bits are forced aligned: halfword uses addr[1] only, word ignores addr[1:0].

Test Plan:
- Reset mid-BUS: assert sys_rst_n = 0 while bus_req = 1, then deliver bus_ack after release -> all outputs 0, FSM in IDLE, no wb_en.
- SB to 0x0000_1003, data 0x0000_00A5, ack after 2 cycles -> bus_addr 0x0000_1000, bus_wstrb 4'b1000, bus_wdata 0xA5A5_A5A5, wb_en stays 0, hold_en low in DONE.
- LB from 0x2001 with bus_rdata 0x1234_80FF, ack on first BUS cycle -> wb_data 0xFFFF_FF80, wb_en one cycle at cycle 2. The same stimulus as LBU -> 0x0000_0080.
- LH from 0x2002 with bus_rdata 0x8001_0000 -> wb_data 0xFFFF_8001. LHU -> 0x0000_8001. LW from 0x2000 -> 0x8001_0000.
- Timeout with TIMEOUT_CYCLES = 4 and no ack -> bus_req high exactly 4 cycles, bus_err one-cycle pulse in DONE, wb_en 0. A second test drives ack on the 4th BUS cycle -> load completes with no bus_err.
- With MEM_MISALIGN_TRAP_EN: LW at 0x3002 -> no bus_req, misalign_err one pulse, hold_en 1 for one cycle. Without the macro -> bus_addr 0x3000, normal completion.
